comparator_serial: RTL and testbench

//  Parametrised multi-cycle magnitude comparator; generalises the fixed 4-bit combinational comparator.

---
 rtl/comparator_serial.sv | 127 ++++++++++++
 tb/tb_comparator_serial.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_serial.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, optional two's-complement mode.
// Define COMPARATOR_SERIAL_EARLY_EXIT_EN to finish on the first differing digit.
module comparator_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             diff_q, diff_d, gt_dir_q, gt_dir_d;
   logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
   logic [DIGIT-1:0] dig_a, dig_b;
   logic             step_diff, step_gt, finish;

   // Operands shift left each step, so the digit under test is always the top one.
   assign dig_a     = a_q[WIDTH-1 -: DIGIT];
   assign dig_b     = b_q[WIDTH-1 -: DIGIT];
   assign step_diff = diff_q | (dig_a != dig_b);
   assign step_gt   = diff_q ? gt_dir_q : (dig_a > dig_b);

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      diff_d    = diff_q;
      gt_dir_d  = gt_dir_q;
      gt_d      = gt_q;
      eq_d      = eq_q;
      lt_d      = lt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      finish    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               // Flipping both sign bits maps two's-complement order onto unsigned order.
               if (is_signed) begin
                  a_d[WIDTH-1] = ~a[WIDTH-1];
                  b_d[WIDTH-1] = ~b[WIDTH-1];
               end
               idx_d    = LAST_IDX;
               diff_d   = 1'b0;
               gt_dir_d = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            a_d      = a_q << DIGIT;
            b_d      = b_q << DIGIT;
            idx_d    = idx_q - IDX_W'(1);
            diff_d   = step_diff;
            gt_dir_d = step_gt;
            finish   = (idx_q == '0);
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
            if (dig_a != dig_b) finish = 1'b1;
`endif
            if (finish) begin
               gt_d    = step_diff & step_gt;
               lt_d    = step_diff & ~step_gt;
               eq_d    = ~step_diff;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         diff_q   <= 1'b0;
         gt_dir_q <= 1'b0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         idx_q    <= idx_d;
         diff_q   <= diff_d;
         gt_dir_q <= gt_dir_d;
         gt_q     <= gt_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
      end
   end

   assign a_gt_b = gt_q;
   assign a_eq_b = eq_q;
   assign a_lt_b = lt_q;

endmodule

// File: tb/tb_comparator_serial.sv
// Self-checking bench for comparator_serial: 16/4 main instance plus 8/1 and 8/8 instances,
// checked against an arithmetic reference model (handles COMPARATOR_SERIAL_EARLY_EXIT_EN too).
module tb_comparator_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, is_signed, out_valid, out_ready;
   logic [15:0] a, b;
   logic        a_gt_b, a_eq_b, a_lt_b;

   logic [7:0]  a8, b8;
   logic        sgn8;
   logic [1:0]  in_valid8, in_ready8, out_valid8, gt8, eq8, lt8;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   comparator_serial #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready),
      .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b));

   comparator_serial #(.WIDTH(8), .DIGIT(1)) dut_w8d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8[0]), .in_ready(in_ready8[0]),
      .a(a8), .b(b8), .is_signed(sgn8), .out_valid(out_valid8[0]), .out_ready(1'b1),
      .a_gt_b(gt8[0]), .a_eq_b(eq8[0]), .a_lt_b(lt8[0]));

   comparator_serial #(.WIDTH(8), .DIGIT(8)) dut_w8d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8[1]), .in_ready(in_ready8[1]),
      .a(a8), .b(b8), .is_signed(sgn8), .out_valid(out_valid8[1]), .out_ready(1'b1),
      .a_gt_b(gt8[1]), .a_eq_b(eq8[1]), .a_lt_b(lt8[1]));

   // Reference: golden signed/unsigned compare; latency from the first differing digit.
   function automatic void model(input longint ua, input longint ub, input int w, input int d,
                                 input bit s, output logic [2:0] f, output int lat);
      longint va   = ua;
      longint vb   = ub;
      int     nd   = w / d;
      longint mask = (longint'(1) << d) - 1;
      if (s && ((ua >> (w - 1)) & 1) == 1) va = va - (longint'(1) << w);
      if (s && ((ub >> (w - 1)) & 1) == 1) vb = vb - (longint'(1) << w);
      f   = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
      lat = nd;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
      for (int i = nd - 1; i >= 0; i--) begin
         if (((ua >> (i * d)) & mask) != ((ub >> (i * d)) & mask)) begin
            lat = nd - i;
            break;
         end
      end
`endif
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      is_signed = 1'b0;
      a         = '0;
      b         = '0;
      a8        = '0;
      b8        = '0;
      sgn8      = 1'b0;
      in_valid8 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One full compare on the 16/4 instance with out_ready held high.
   task automatic run16(input logic [15:0] ta, input logic [15:0] tbv, input bit s, input string tag);
      logic [2:0] exp_f;
      int         exp_lat, lat, wait_cnt;
      model(longint'(ta), longint'(tbv), 16, 4, s, exp_f, exp_lat);
      wait_cnt = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s in_ready_wait: got %b want 1", tag, in_ready);
      end
      a = ta; b = tbv; is_signed = s; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      tests_run++;
      if (lat !== exp_lat) begin
         tests_failed++;
         $display("FAIL %s latency: got %0d want %0d (a=%h b=%h s=%0b)", tag, lat, exp_lat, ta, tbv, s);
      end
      tests_run++;
      if ({a_gt_b, a_eq_b, a_lt_b} !== exp_f) begin
         tests_failed++;
         $display("FAIL %s flags gt/eq/lt: got %b want %b (a=%h b=%h s=%0b)",
                  tag, {a_gt_b, a_eq_b, a_lt_b}, exp_f, ta, tbv, s);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b} !== {2'b10, exp_f}) begin
         tests_failed++;
         $display("FAIL %s after_handshake rdy/vld/flags: got %b want %b",
                  tag, {in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b}, {2'b10, exp_f});
      end
   endtask

   // One compare on an 8-bit instance (u=0: DIGIT=1, u=1: DIGIT=8).
   task automatic run8(input int u, input logic [7:0] ta, input logic [7:0] tbv, input bit s);
      logic [2:0] exp_f;
      int         exp_lat, lat;
      model(longint'(ta), longint'(tbv), 8, (u == 0) ? 1 : 8, s, exp_f, exp_lat);
      @(negedge clk);
      tests_run++;
      if (in_ready8[u] !== 1'b1) begin
         tests_failed++;
         $display("FAIL w8[%0d] in_ready: got %b want 1", u, in_ready8[u]);
      end
      a8 = ta; b8 = tbv; sgn8 = s; in_valid8[u] = 1'b1;
      @(posedge clk);
      #1 in_valid8[u] = 1'b0;
      lat = 0;
      while (out_valid8[u] !== 1'b1 && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
      tests_run++;
      if (lat !== exp_lat || {gt8[u], eq8[u], lt8[u]} !== exp_f) begin
         tests_failed++;
         $display("FAIL w8[%0d] result: lat %0d flags %b want lat %0d flags %b (a=%h b=%h s=%0b)",
                  u, lat, {gt8[u], eq8[u], lt8[u]}, exp_lat, exp_f, ta, tbv, s);
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      tests_run++;
      if ({in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b} !== 5'b10000) begin
         tests_failed++;
         $display("FAIL reset rdy/vld/flags: got %b want 10000", {in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b});
      end
      tests_run++;
      if ({in_ready8, out_valid8, gt8, eq8, lt8} !== 10'b11_00_00_00_00) begin
         tests_failed++;
         $display("FAIL reset w8 state: got %b want 1100000000", {in_ready8, out_valid8, gt8, eq8, lt8});
      end
   endtask

   task automatic test_directed();
      run16(16'h1234, 16'h1234, 1'b0, "eq_1234");
      run16(16'h8000, 16'h7FFF, 1'b0, "unsigned_8000_7fff");
      run16(16'h8000, 16'h7FFF, 1'b1, "signed_8000_7fff");
      run16(16'h0001, 16'h0002, 1'b0, "lt_last_digit");
      run16(16'hFFFF, 16'h0000, 1'b1, "signed_m1_0");
      run16(16'h7FFF, 16'h7FFE, 1'b1, "signed_max");
   endtask

   task automatic test_random();
      logic [15:0] ta, tbv, keep;
      int          k;
      for (int n = 0; n < 150; n++) begin
         ta  = 16'($urandom);
         tbv = 16'($urandom);
         k   = $urandom_range(0, 4);
         keep = 16'h0000;
         if (k > 0) begin
            keep = 16'hFFFF;
            keep = keep << (16 - 4 * k);
         end
         tbv = (ta & keep) | (tbv & ~keep);
         run16(ta, tbv, 1'($urandom_range(0, 1)), "random");
      end
   endtask

   task automatic test_backpressure();
      int wait_cnt = 0;
      out_ready = 1'b0;
      @(negedge clk);
      a = 16'hA5A5; b = 16'hA5A4; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      while (out_valid !== 1'b1 && wait_cnt < 50) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a = 16'h0000; b = 16'hFFFF; in_valid = 1'b1;
         @(posedge clk);
         #1;
         tests_run++;
         if ({out_valid, in_ready, a_gt_b, a_eq_b, a_lt_b} !== 5'b10100) begin
            tests_failed++;
            $display("FAIL backpressure cycle %0d vld/rdy/flags: got %b want 10100",
                     i, {out_valid, in_ready, a_gt_b, a_eq_b, a_lt_b});
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if ({out_valid, in_ready, a_gt_b, a_eq_b, a_lt_b} !== 5'b01100) begin
         tests_failed++;
         $display("FAIL backpressure release vld/rdy/flags: got %b want 01100",
                  {out_valid, in_ready, a_gt_b, a_eq_b, a_lt_b});
      end
      run16(16'h0F00, 16'h0F01, 1'b0, "after_backpressure");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      a = 16'h4321; b = 16'h4321; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b} !== 5'b10000) begin
         tests_failed++;
         $display("FAIL reset_mid rdy/vld/flags: got %b want 10000", {in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b});
      end
      @(negedge clk);
      rst_n = 1'b1;
      run16(16'hC000, 16'h4000, 1'b1, "after_reset_mid");
   endtask

   task automatic test_back_to_back();
      run16(16'h0000, 16'h0000, 1'b0, "b2b_0");
      run16(16'hFFFF, 16'hFFFF, 1'b1, "b2b_1");
      run16(16'h1000, 16'h0FFF, 1'b0, "b2b_2");
   endtask

   task automatic test_sweep8();
      logic [7:0] corner_a [6] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'h01};
      logic [7:0] corner_b [6] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h80, 8'hFF};
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 6; i++) begin
            run8(u, corner_a[i], corner_b[i], 1'b0);
            run8(u, corner_a[i], corner_b[i], 1'b1);
         end
         for (int n = 0; n < 250; n++)
            run8(u, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_sweep8();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
